// File: rtl/alu_multiciclo.sv
// Registered ALU with start/busy/done handshake; MUL, DIV and MOD run iteratively,
// one operand bit per clock.
module alu_multiciclo #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [5:0]         opcode,
    input  logic [WIDTH-1:0]   input1,
    input  logic [WIDTH-1:0]   input2,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               branch,
    output logic [WIDTH-1:0]   result,
    output logic               sinalBranch,
    output logic               busy,
    output logic               done,
    output logic               divZero
);

    localparam logic [5:0] OpAdd = 6'h00, OpSub = 6'h01, OpAnd = 6'h02, OpOr  = 6'h03;
    localparam logic [5:0] OpNot = 6'h04, OpSll = 6'h05, OpSrl = 6'h06, OpMul = 6'h07;
    localparam logic [5:0] OpDiv = 6'h08, OpMod = 6'h09, OpDec = 6'h0A, OpXor = 6'h0B;
    localparam logic [5:0] OpBeq = 6'h11, OpBne = 6'h12, OpBgt = 6'h15, OpSlt = 6'h17;
    localparam logic [5:0] OpSeq = 6'h1E, OpSgt = 6'h20, OpSne = 6'h22, OpMov = 6'h1B;

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  a_q, b_q, acc_q, rem_q;
    logic              is_mod_q;
    logic [WIDTH-1:0]  result_q;
    logic              sinal_q, busy_q, done_q, div_zero_q;

    logic [WIDTH-1:0]  sc_result;
    logic              sc_flag;
    logic [WIDTH-1:0]  acc_d, rem_d, quo_d;
    logic [WIDTH:0]    rem_sh, diff;

    always_comb begin
        sc_result = '0;
        sc_flag   = 1'b0;
        case (opcode)
            OpAdd: sc_result = input1 + input2;
            OpSub: sc_result = input1 - input2;
            OpAnd: sc_result = input1 & input2;
            OpOr:  sc_result = input1 | input2;
            OpNot: sc_result = ~input1;
            OpSll: sc_result = input1 << shamt;
            OpSrl: sc_result = input1 >> shamt;
            OpDec: sc_result = input1 - WIDTH'(1);
            OpXor: sc_result = input1 ^ input2;
            OpBeq: sc_flag   = (input1 == input2);
            OpBne: sc_flag   = (input1 != input2);
            OpBgt: sc_flag   = (input1 > input2);
            OpSlt: sc_result = WIDTH'(input1 < input2);
            OpSeq: sc_result = WIDTH'(input1 == input2);
            OpSgt: sc_result = WIDTH'(input1 > input2);
            OpSne: sc_result = WIDTH'(input1 != input2);
            OpMov: sc_result = input1;
            default: ;
        endcase
    end

    // Shift-add step for MUL; restoring step for DIV (a_q doubles as the quotient shifter).
    always_comb begin
        acc_d  = b_q[0] ? (acc_q + a_q) : acc_q;
        rem_sh = {rem_q, a_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, b_q};
        rem_d  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d  = {a_q[WIDTH-2:0], ~diff[WIDTH]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            is_mod_q   <= 1'b0;
            result_q   <= '0;
            sinal_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (opcode == OpMul) begin
                            a_q     <= input1;
                            b_q     <= input2;
                            acc_q   <= '0;
                            cnt_q   <= CntInit;
                            busy_q  <= 1'b1;
                            state_q <= StMul;
                        end else if ((opcode == OpDiv || opcode == OpMod) && input2 != '0) begin
                            a_q      <= input1;
                            b_q      <= input2;
                            rem_q    <= '0;
                            is_mod_q <= (opcode == OpMod);
                            cnt_q    <= CntInit;
                            busy_q   <= 1'b1;
                            state_q  <= StDiv;
                        end else if (opcode == OpDiv || opcode == OpMod) begin
                            result_q   <= (opcode == OpDiv) ? '1 : input1;
                            sinal_q    <= 1'b0;
                            div_zero_q <= 1'b1;
                            done_q     <= 1'b1;
                            state_q    <= StFin;
                        end else begin
                            result_q   <= sc_result;
                            sinal_q    <= sc_flag & branch;
                            div_zero_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= StFin;
                        end
                    end
                end
                StMul: begin
                    acc_q <= acc_d;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        result_q   <= acc_d;
                        sinal_q    <= 1'b0;
                        div_zero_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= StFin;
                    end
                end
                StDiv: begin
                    rem_q <= rem_d;
                    a_q   <= quo_d;
                    cnt_q <= cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        result_q   <= is_mod_q ? rem_d : quo_d;
                        sinal_q    <= 1'b0;
                        div_zero_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= StFin;
                    end
                end
                StFin: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign result      = result_q;
    assign sinalBranch = sinal_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign divZero     = div_zero_q;

endmodule
